// File: rtl/serial_pattern_ctrl.sv
// serial_pattern_ctrl: accepts parallel words on a valid/ready port and
// serialises them MSB-first, one bit per cycle. It runs a programmable
// 1..8 bit pattern detector (overlapping or not) over that stream, keeps a
// saturating match count and raises a sticky threshold interrupt.
module serial_pattern_ctrl #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             cfg_en,
  input  logic [7:0]       cfg_pattern,
  input  logic [2:0]       cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W-1:0]     s_data,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             irq,
  output logic             busy
);

  localparam int BCW = (W > 2) ? $clog2(W) : 1;
  localparam logic [BCW-1:0] LAST_IDX = BCW'(W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Serialiser state
  state_t         state_q;
  logic [W-1:0]   shreg_q;
  logic [BCW-1:0] bit_cnt_q;

  // Configuration captured when a word is accepted
  logic [7:0]     pat_q;
  logic [2:0]     len_q;
  logic           ovl_q;

  // Detector state
  logic [7:0]       hist_q;
  logic [3:0]       fill_q;
  logic             match_q;
  logic [CNT_W-1:0] match_count_q;
  logic             irq_q;

  // Combinational helpers
  logic             last_bit;
  logic             accept;
  logic             shifting;
  logic             cur_bit;
  logic [7:0]       hist_d;
  logic [7:0]       len_mask;
  logic             fill_ok;
  logic             hit;
  logic [3:0]       fill_inc;
  logic [CNT_W-1:0] count_inc;

  assign shifting = (state_q == SHIFT);
  assign last_bit = shifting && (bit_cnt_q == LAST_IDX);
  assign cur_bit  = shifting & shreg_q[W-1];

  // Reset is folded in so that s_ready reads 0 for the whole reset interval
  // and no word can be taken while the block is held in reset.
  assign s_ready  = !reset && cfg_en && (!shifting || last_bit);
  assign accept   = s_valid && s_ready;

  // Only the low len bits of history/pattern take part in the compare.
  for (genvar gi = 0; gi < 8; gi++) begin : g_mask
    assign len_mask[gi] = (3'(gi) <= len_q);
  end

  // History as it will look once the current bit has been shifted in.
  assign hist_d    = {hist_q[6:0], cur_bit};
  // fill+1 >= len+1 reduces to fill >= len_q.
  assign fill_ok   = (fill_q >= {1'b0, len_q});
  assign hit       = shifting && fill_ok && (((hist_d ^ pat_q) & len_mask) == 8'h00);
  assign fill_inc  = (fill_q == 4'd8) ? 4'd8 : fill_q + 4'd1;
  assign count_inc = (match_count_q == {CNT_W{1'b1}}) ? match_count_q
                                                      : match_count_q + CNT_W'(1);

  // Serialiser FSM: loads accepted words, shifts MSB-first, reloads on the
  // last bit for a gapless stream when another word is offered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shreg_q   <= s_data;
            bit_cnt_q <= '0;
            pat_q     <= cfg_pattern;
            len_q     <= cfg_len;
            ovl_q     <= cfg_overlap;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            if (accept) begin
              shreg_q   <= s_data;
              bit_cnt_q <= '0;
              pat_q     <= cfg_pattern;
              len_q     <= cfg_len;
              ovl_q     <= cfg_overlap;
            end else begin
              shreg_q   <= '0;
              bit_cnt_q <= '0;
              state_q   <= IDLE;
            end
          end else begin
            shreg_q   <= {shreg_q[W-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + BCW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Detector: history/fill update per serial bit, match pulse, saturating
  // count and sticky irq. clear overrides everything including a hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q        <= '0;
      fill_q        <= '0;
      match_q       <= 1'b0;
      match_count_q <= '0;
      irq_q         <= 1'b0;
    end else if (clear) begin
      hist_q        <= '0;
      fill_q        <= '0;
      match_q       <= 1'b0;
      match_count_q <= '0;
      irq_q         <= 1'b0;
    end else begin
      match_q <= hit;
      if (shifting) begin
        hist_q <= hist_d;
        fill_q <= (hit && !ovl_q) ? 4'd0 : fill_inc;
      end
      if (hit) begin
        match_count_q <= count_inc;
        if ((cfg_thresh != '0) && (count_inc == cfg_thresh)) begin
          irq_q <= 1'b1;
        end
      end
    end
  end

  assign ser_bit     = cur_bit;
  assign ser_valid   = shifting;
  assign busy        = shifting;
  assign match       = match_q;
  assign match_count = match_count_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_serial_pattern_ctrl.sv
// Bench for serial_pattern_ctrl: a queue-based bit-stream model predicts all
// outputs every cycle; directed scenarios add hand-computed literal checks.
module tb_serial_pattern_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clear, cfg_en, cfg_overlap, s_valid;
  logic [7:0]  cfg_pattern;
  logic [2:0]  cfg_len;
  logic [15:0] cfg_thresh;
  logic [1:0]  cfg_thresh2;
  logic [W-1:0] s_data;

  logic        s_ready, ser_bit, ser_valid, match, irq, busy;
  logic [15:0] match_count;
  logic        s_ready2, ser_bit2, ser_valid2, match2, irq2, busy2;
  logic [1:0]  match_count2;

  serial_pattern_ctrl #(.W(W), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .clear(clear), .cfg_en(cfg_en),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_thresh(cfg_thresh), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .ser_bit(ser_bit), .ser_valid(ser_valid),
    .match(match), .match_count(match_count), .irq(irq), .busy(busy)
  );

  serial_pattern_ctrl #(.W(W), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .clear(clear), .cfg_en(cfg_en),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_thresh(cfg_thresh2), .s_valid(s_valid), .s_ready(s_ready2),
    .s_data(s_data), .ser_bit(ser_bit2), .ser_valid(ser_valid2),
    .match(match2), .match_count(match_count2), .irq(irq2), .busy(busy2)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic       b;
    logic [7:0] pat;
    int         len;
    logic       ovl;
  } mbit_t;

  mbit_t bq[$];       // bits still to be emitted, each with its word's config
  int    hist[$];     // stream bits since the last flush, newest at the back
  int    fresh = 0;   // bits counted towards the next match
  int    raw   = 0;   // unsaturated match count since the last flush
  logic  m_match = 1'b0;
  logic  m_irq   = 1'b0;
  mbit_t cur, nb;
  logic  m_hit, m_had, m_acc;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bq.delete(); hist.delete();
      fresh = 0; raw = 0; m_match = 1'b0; m_irq = 1'b0;
    end else begin
      m_acc   = s_valid && cfg_en && (bq.size() <= 1);
      m_had   = (bq.size() > 0);
      m_match = 1'b0;
      if (clear) begin
        if (m_had) void'(bq.pop_front());
        hist.delete(); fresh = 0; raw = 0; m_irq = 1'b0;
      end else if (m_had) begin
        cur = bq.pop_front();
        hist.push_back(int'(cur.b));
        if (hist.size() > 8) void'(hist.pop_front());
        m_hit = (fresh + 1 >= cur.len);
        for (int i = 0; i < cur.len; i++) begin
          if (hist.size() <= i) m_hit = 1'b0;
          else if (hist[hist.size()-1-i] != int'(cur.pat[i])) m_hit = 1'b0;
        end
        m_match = m_hit;
        fresh = (m_hit && !cur.ovl) ? 0 : ((fresh < 8) ? fresh + 1 : 8);
        if (m_hit) begin
          raw++;
          if (cfg_thresh != 16'd0 && sat(raw, 65535) == int'(cfg_thresh)) m_irq = 1'b1;
        end
      end
      if (m_acc) begin
        for (int i = W - 1; i >= 0; i--) begin
          nb.b = s_data[i]; nb.pat = cfg_pattern;
          nb.len = int'(cfg_len) + 1; nb.ovl = cfg_overlap;
          bq.push_back(nb);
        end
      end
    end
  end

  // Compare process: every output of both instances against the model.
  always @(negedge clk) begin
    logic e_valid, e_bit, e_ready;
    e_valid = (bq.size() > 0);
    e_bit   = e_valid ? bq[0].b : 1'b0;
    e_ready = !reset && cfg_en && (bq.size() <= 1);
    check("ser_valid", ser_valid, e_valid);
    check("ser_bit", ser_bit, e_bit);
    check("busy", busy, e_valid);
    check("s_ready", s_ready, e_ready);
    check("match", match, m_match);
    check("match_count", match_count, sat(raw, 65535));
    check("irq", irq, m_irq);
    check("ser_bit2", ser_bit2, e_bit);
    check("s_ready2", s_ready2, e_ready);
    check("match2", match2, m_match);
    check("match_count2", match_count2, sat(raw, 3));
    check("irq2", irq2, 1'b0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offers a word and returns just after the accepting edge (first bit visible).
  task automatic send_word(input logic [7:0] d, input logic [7:0] pat,
                           input logic [2:0] len, input logic ovl, input bit keep);
    int n;
    s_valid = 1'b1; s_data = d;
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    #1;
    n = 0;
    while (!s_ready && n < 100) begin cyc(); n++; end
    if (!s_ready) begin
      n_checks++; n_err++;
      $display("FAIL accept_timeout: s_ready stayed 0, required 1 at %0t", $time);
    end
    cyc();
    if (!keep) begin
      s_valid = 1'b0;
      s_data  = W'($urandom);
    end
    // Configuration changes mid-word must have no effect.
    cfg_pattern = 8'($urandom); cfg_len = 3'($urandom); cfg_overlap = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin cyc(); n++; end
    if (busy) begin
      n_checks++; n_err++;
      $display("FAIL idle_timeout: busy stayed 1, required 0 at %0t", $time);
    end
    cyc();
  endtask

  task automatic pulse_clear();
    clear = 1'b1; cyc(); clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clear = 1'b0; cfg_en = 1'b0; s_valid = 1'b0; s_data = '0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    cfg_thresh = '0; cfg_thresh2 = '0;
    cyc(); cyc();
    check("rst_ready", s_ready, 0);
    check("rst_valid", ser_valid, 0);
    check("rst_count", match_count, 0);
    reset = 1'b0; cyc();
    check("ready_no_en", s_ready, 0);
    cfg_en = 1'b1; #1;
    check("ready_en", s_ready, 1);

    // 1: F0, pattern 11, non-overlap -> matches after bits 2 and 4
    pulse_clear();
    send_word(8'hF0, 8'h03, 3'd1, 1'b0, 1'b0);
    check("t1_first_bit", ser_bit, 1);
    wait_idle();
    check("t1_count", match_count, 2);
    check("t1_model", raw, 2);

    // 2: overlap variants
    pulse_clear();
    send_word(8'hF0, 8'h03, 3'd1, 1'b1, 1'b0);
    wait_idle();
    check("t2_f0_ovl", match_count, 3);
    pulse_clear();
    send_word(8'hAA, 8'h05, 3'd2, 1'b1, 1'b0);
    wait_idle();
    check("t2_aa_ovl", match_count, 3);
    pulse_clear();
    send_word(8'hAA, 8'h05, 3'd2, 1'b0, 1'b0);
    wait_idle();
    check("t2_aa_novl", match_count, 2);
    check("t2_model", raw, 2);

    // 3: back-to-back 01, 80 -> one match across the boundary
    pulse_clear();
    send_word(8'h01, 8'h03, 3'd1, 1'b0, 1'b1);
    send_word(8'h80, 8'h03, 3'd1, 1'b0, 1'b0);
    wait_idle();
    check("t3_count", match_count, 1);

    // cfg_en dropped mid-word: word finishes, then idle despite s_valid
    pulse_clear();
    send_word(8'h0F, 8'h03, 3'd1, 1'b0, 1'b1);
    cfg_en = 1'b0; s_data = 8'hFF;
    repeat (12) cyc();
    check("t7_idle", busy, 0);
    check("t7_count", match_count, 2);
    s_valid = 1'b0; cfg_en = 1'b1;

    // 4: threshold interrupt and clear
    pulse_clear();
    cfg_thresh = 16'd3;
    send_word(8'hFF, 8'h03, 3'd1, 1'b0, 1'b0);
    wait_idle();
    check("t4_irq", irq, 1);
    check("t4_count", match_count, 4);
    check("t4_count2_sat", match_count2, 3);
    pulse_clear();
    check("t4_irq_clr", irq, 0);
    check("t4_count_clr", match_count, 0);
    cfg_thresh = 16'd0;

    // 5: clear coincides with the bit that would complete a match
    send_word(8'hFF, 8'h03, 3'd1, 1'b0, 1'b0);
    cyc();
    clear = 1'b1; cyc(); clear = 1'b0;
    check("t5_no_match", match, 0);
    check("t5_count0", match_count, 0);
    wait_idle();
    check("t5_count", match_count, 3);

    // 6: reset mid-word, then saturation of the 2-bit counter
    pulse_clear();
    send_word(8'hF0, 8'h03, 3'd1, 1'b0, 1'b0);
    cyc(); cyc();
    check("t6_pre", match_count, 1);
    reset = 1'b1; #1;
    check("t6_rst_valid", ser_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ready", s_ready, 0);
    check("t6_rst_count", match_count, 0);
    cyc();
    reset = 1'b0; #1;
    check("t6_ready", s_ready, 1);
    send_word(8'h3F, 8'h03, 3'd1, 1'b1, 1'b0);
    check("t6_msb", ser_bit, 0);
    wait_idle();
    check("t6_count", match_count, 5);
    check("t6_count2", match_count2, 3);

    repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
